// File: rtl/scalar_write_arbiter.sv
// Two-requester round-robin arbiter feeding a bank of scalar registers via one-hot write enables.
// Latency: one cycle from accept to wr_en. Backpressure: hold or a lost arbitration drops ready.
module scalar_write_arbiter #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [WIDTH-1:0]    req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [WIDTH-1:0]    req1_data,
  output logic                req1_ready,
  input  logic                hold,
  output logic [NUM_REGS-1:0] wr_en,
  output logic [WIDTH-1:0]    wr_data,
  output logic                wr_src,
  output logic                addr_err,
  output logic [15:0]         wr_count
);

  logic                ptr_q, ptr_d;
  logic [NUM_REGS-1:0] wr_en_q, wr_en_d;
  logic [WIDTH-1:0]    wr_data_q, wr_data_d;
  logic                wr_src_q, wr_src_d;
  logic                addr_err_q, addr_err_d;
  logic [15:0]         wr_count_q, wr_count_d;

  logic                grant0, grant1;
  logic                accept;
  logic [ADDR_W-1:0]   sel_addr;
  logic                in_range;

  // ptr_q names the requester that wins when both are valid.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && !hold) begin
      if (req0_valid && req1_valid) begin
        grant0 = ~ptr_q;
        grant1 = ptr_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = (req0_valid & grant0) | (req1_valid & grant1);
  assign sel_addr   = grant1 ? req1_addr : req0_addr;
  assign in_range   = int'(sel_addr) < NUM_REGS;

  always_comb begin
    ptr_d      = ptr_q;
    wr_data_d  = wr_data_q;
    wr_src_d   = wr_src_q;
    wr_en_d    = '0;
    addr_err_d = 1'b0;
    wr_count_d = wr_count_q;
    if (accept) begin
      ptr_d     = ~grant1;
      wr_data_d = grant1 ? req1_data : req0_data;
      wr_src_d  = grant1;
      if (in_range) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          wr_en_d[i] = (sel_addr == ADDR_W'(i));
        end
        wr_count_d = wr_count_q + 16'd1;
      end else begin
        addr_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= 1'b0;
      wr_en_q    <= '0;
      wr_data_q  <= '0;
      wr_src_q   <= 1'b0;
      addr_err_q <= 1'b0;
      wr_count_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      wr_src_q   <= wr_src_d;
      addr_err_q <= addr_err_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_data  = wr_data_q;
  assign wr_src   = wr_src_q;
  assign addr_err = addr_err_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_scalar_write_arbiter.sv
// Directed bench for scalar_write_arbiter: a 16-register instance plus an 8-register instance sharing stimulus.
module tb_scalar_write_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid, hold;
  logic [3:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;

  logic        req0_ready, req1_ready, wr_src, addr_err;
  logic [15:0] wr_en;
  logic [31:0] wr_data;
  logic [15:0] wr_count;

  logic        e8_req0_ready, e8_req1_ready, e8_wr_src, e8_addr_err;
  logic [7:0]  e8_wr_en;
  logic [31:0] e8_wr_data;
  logic [15:0] e8_wr_count;

  int errors = 0;
  int checks = 0;

  scalar_write_arbiter #(.WIDTH(32), .NUM_REGS(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .hold(hold), .wr_en(wr_en), .wr_data(wr_data), .wr_src(wr_src),
    .addr_err(addr_err), .wr_count(wr_count)
  );

  scalar_write_arbiter #(.WIDTH(32), .NUM_REGS(8), .ADDR_W(4)) dut8 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(e8_req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(e8_req1_ready),
    .hold(hold), .wr_en(e8_wr_en), .wr_data(e8_wr_data), .wr_src(e8_wr_src),
    .addr_err(e8_addr_err), .wr_count(e8_wr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    hold       = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    req0_valid = 1'b1; req0_addr = 4'd2; req0_data = 32'hDEAD;
    tick();
    #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b want 0", req0_ready); end
    checks++; if (wr_en !== 16'h0) begin errors++; $display("FAIL reset_wr_en: got %h want 0000", wr_en); end
    checks++; if (wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
    checks++; if (wr_src !== 1'b0 || addr_err !== 1'b0) begin errors++; $display("FAIL reset_src_err: got %b%b want 00", wr_src, addr_err); end
    tick();
    checks++; if (wr_en !== 16'h0 || wr_count !== 16'd0) begin errors++; $display("FAIL reset_no_accept: wr_en %h cnt %0d want 0000/0", wr_en, wr_count); end
    idle();
    rst = 1'b0;
    tick();
  endtask

  // V1
  task automatic test_single();
    req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 32'hC;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready: got %b%b want 10", req0_ready, req1_ready); end
    tick();
    idle();
    checks++; if (wr_en !== 16'h0008) begin errors++; $display("FAIL single_wr_en: got %h want 0008", wr_en); end
    checks++; if (wr_data !== 32'hC || wr_src !== 1'b0) begin errors++; $display("FAIL single_data: got %h/%b want c/0", wr_data, wr_src); end
    checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL single_count: got %0d want 1", wr_count); end
    tick();
    checks++; if (wr_en !== 16'h0 || wr_data !== 32'hC || wr_count !== 16'd1) begin errors++; $display("FAIL idle_hold: wr_en %h data %h cnt %0d want 0000/c/1", wr_en, wr_data, wr_count); end
  endtask

  // V2: arbitration and alternation
  task automatic test_both_valid();
    do_reset();
    req0_valid = 1'b1; req0_addr = 4'd1; req0_data = 32'hA;
    req1_valid = 1'b1; req1_addr = 4'd2; req1_data = 32'hB;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL both_ready_c1: got %b%b want 10", req0_ready, req1_ready); end
    tick();
    checks++; if (wr_en !== 16'h0002 || wr_data !== 32'hA || wr_src !== 1'b0) begin errors++; $display("FAIL both_commit1: %h/%h/%b want 0002/a/0", wr_en, wr_data, wr_src); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin errors++; $display("FAIL both_ready_c2: got %b%b want 01", req0_ready, req1_ready); end
    tick();
    idle();
    checks++; if (wr_en !== 16'h0004 || wr_data !== 32'hB || wr_src !== 1'b1) begin errors++; $display("FAIL both_commit2: %h/%h/%b want 0004/b/1", wr_en, wr_data, wr_src); end
    checks++; if (wr_count !== 16'd2) begin errors++; $display("FAIL both_count: got %0d want 2", wr_count); end
    tick();
  endtask

  // V3
  task automatic test_hold();
    hold = 1'b1;
    req1_valid = 1'b1; req1_addr = 4'd7; req1_data = 32'h77;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req1_ready !== 1'b0 || req0_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d]: got %b%b want 00", i, req0_ready, req1_ready); end
      tick();
      checks++; if (wr_en !== 16'h0) begin errors++; $display("FAIL hold_wr_en[%0d]: got %h want 0000", i, wr_en); end
    end
    hold = 1'b0;
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready: got %b want 1", req1_ready); end
    tick();
    idle();
    checks++; if (wr_en !== 16'h0080 || wr_data !== 32'h77 || wr_src !== 1'b1 || wr_count !== 16'd3) begin errors++; $display("FAIL hold_commit: %h/%h/%b/%0d want 0080/77/1/3", wr_en, wr_data, wr_src, wr_count); end
    tick();
  endtask

  // V4
  task automatic test_addr_err();
    req0_valid = 1'b1; req0_addr = 4'd15; req0_data = 32'h5;
    #1;
    checks++; if (e8_req0_ready !== 1'b1) begin errors++; $display("FAIL err_ready: got %b want 1", e8_req0_ready); end
    tick();
    idle();
    checks++; if (e8_wr_en !== 8'h0 || e8_addr_err !== 1'b1) begin errors++; $display("FAIL err_pulse: wr_en %h err %b want 00/1", e8_wr_en, e8_addr_err); end
    checks++; if (e8_wr_count !== 16'd3) begin errors++; $display("FAIL err_count: got %0d want 3", e8_wr_count); end
    checks++; if (wr_en !== 16'h8000 || addr_err !== 1'b0 || wr_count !== 16'd4) begin errors++; $display("FAIL top_reg15: %h/%b/%0d want 8000/0/4", wr_en, addr_err, wr_count); end
    tick();
    checks++; if (e8_addr_err !== 1'b0 || e8_wr_count !== 16'd3) begin errors++; $display("FAIL err_one_cycle: err %b cnt %0d want 0/3", e8_addr_err, e8_wr_count); end
  endtask

  // V5
  task automatic test_same_addr();
    logic [31:0] reg5;
    reg5 = 32'h0;
    do_reset();
    req0_valid = 1'b1; req0_addr = 4'd5; req0_data = 32'h1;
    req1_valid = 1'b1; req1_addr = 4'd5; req1_data = 32'h2;
    tick();
    if (wr_en[5]) reg5 = wr_data;
    checks++; if (wr_en !== 16'h0020 || wr_data !== 32'h1 || wr_src !== 1'b0) begin errors++; $display("FAIL same_first: %h/%h/%b want 0020/1/0", wr_en, wr_data, wr_src); end
    tick();
    idle();
    if (wr_en[5]) reg5 = wr_data;
    checks++; if (wr_en !== 16'h0020 || wr_data !== 32'h2 || wr_src !== 1'b1) begin errors++; $display("FAIL same_second: %h/%h/%b want 0020/2/1", wr_en, wr_data, wr_src); end
    checks++; if (reg5 !== 32'h2) begin errors++; $display("FAIL same_final: reg5 %h want 2", reg5); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_en;
    req0_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req0_addr = 4'(i);
      req0_data = 32'h10 + 32'(i);
      tick();
      exp_en = 16'h1 << i;
      checks++; if (wr_en !== exp_en || wr_data !== 32'h10 + 32'(i)) begin errors++; $display("FAIL b2b[%0d]: %h/%h want %h/%h", i, wr_en, wr_data, exp_en, 32'h10 + 32'(i)); end
    end
    idle();
    checks++; if (wr_count !== 16'd6) begin errors++; $display("FAIL b2b_count: got %0d want 6", wr_count); end
    tick();
  endtask

  // V6
  task automatic test_reset_mid();
    req0_valid = 1'b1; req0_addr = 4'd9; req0_data = 32'h99;
    tick();
    rst = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_in_rst: got %b%b want 00", req0_ready, req1_ready); end
    tick();
    rst = 1'b0;
    checks++; if (wr_en !== 16'h0 || wr_count !== 16'd0) begin errors++; $display("FAIL mid_discard: wr_en %h cnt %0d want 0000/0", wr_en, wr_count); end
    req1_valid = 1'b1; req1_addr = 4'd4; req1_data = 32'h44;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL mid_ptr_reset: got %b%b want 10", req0_ready, req1_ready); end
    idle();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    req0_addr = '0; req0_data = '0;
    req1_addr = '0; req1_data = '0;
    test_reset();
    test_single();
    test_both_valid();
    test_hold();
    test_addr_err();
    test_same_addr();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
